lcd_reader: RTL
===============

# lcd_reader

Read-side companion to the LCD write controller. Runs HD44780-style read cycles (RW=1) on request, either as one read of data RAM / status or as a busy-flag poll that repeats until BF (bit 7) clears or a retry limit is hit. Sits between the LCD init/command sequencer and the LCD pins. The sequencer muxes LCD_EN/LCD_RS/LCD_RW with the writer, using oBusy to select this block.

## Interface
- CLK_Divide, 16: iCLK cycles LCD_EN is held high per read (tPW, data access).
- RECOVER, 16: iCLK cycles LCD_EN is held low after each read before completing or re-polling (tcycle).
- POLL_MAX, 255: maximum reads in poll mode (1..255).
- iCLK  in  1  system clock; all state on rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iStart  in  1  request; only a rising edge (registered previous value 0, current 1) starts a transaction.
- iRS  in  1  register select for the transaction; latched at start.
- iPoll  in  1  1 = busy-flag poll mode, 0 = single read; latched at start.
- LCD_DATA  in  8  LCD data bus; the block never drives it.
- oDATA  out  8  last captured byte; holds until the next capture.
- oDone  out  1  level; set at completion, cleared by the next accepted start.
- oTimeout  out  1  level; set if the poll ended with BF still 1, cleared by the next accepted start.
- oBusy  out  1  high from accepted start until completion.
- LCD_EN  out  1  LCD enable strobe.
- LCD_RW  out  1  1 while oBusy, else 0.
- LCD_RS  out  1  latched iRS while oBusy, else 0.

## Operation
- States:
  - IDLE: waiting for a start.
  - SETUP: address setup, one cycle.
  - EN_HI: LCD_EN high, counting CLK_Divide.
  - RECOV: LCD_EN low, counting RECOVER.
- IDLE → SETUP on start edge.
  - At that edge: latch iRS and iPoll; set oBusy=1, LCD_RW=1; clear oDone, oTimeout and the poll count.
- Start edges during oBusy are ignored; there is no queue.
- SETUP → EN_HI: assert LCD_EN and clear the cycle counter.
- EN_HI: count while cnt < CLK_Divide−1.
  - On the terminal edge: deassert LCD_EN, load oDATA ← LCD_DATA (same edge), increment the poll count, go to RECOV.
- RECOV: count to RECOVER−1, then:
  - Single read: complete.
  - Poll, oDATA[7]=0: complete.
  - Poll, oDATA[7]=1 and poll count = POLL_MAX: complete with oTimeout=1.
  - Otherwise: go to SETUP, with RW and RS held.
- On completion: oDone=1, oBusy=0, LCD_RW=0, LCD_RS=0, state IDLE.
- Counter width is sized to max(CLK_Divide, RECOVER). The poll counter is 8 bits; wrap cannot occur since POLL_MAX ≤ 255.
- Reset (async, any state):
  - State IDLE.
  - oDATA=0; oDone, oTimeout, oBusy, LCD_EN, LCD_RW, LCD_RS all 0.
  - Edge-detect register = 0: an iStart already high at reset release counts as an edge one cycle later.

## Timing
- T0 = edge at which the start edge is accepted.
- LCD_RW and LCD_RS become valid at T0. LCD_EN rises at T0+1, one cycle after them (tAS).
- LCD_EN is high for exactly CLK_Divide cycles and falls at T0+1+CLK_Divide, the same edge at which oDATA is captured.
- Single read: oDone rises at T0+1+CLK_Divide+RECOVER, which is T33 with defaults.
- Poll of N reads: oDone rises at T0 + N·(1+CLK_Divide+RECOVER), i.e. N·33 with defaults.
- LCD_RW stays 1 from T0 until the completion edge. LCD_RW/LCD_RS never change while LCD_EN=1.
- The earliest new start is accepted one cycle after oDone rises.

## Test plan
- Single read, defaults: iRS=1, iPoll=0, LCD_DATA=0xA5, one-cycle iStart pulse → LCD_EN high for exactly 16 cycles starting T1; oDATA=0xA5 and oDone=1 at T33; LCD_RW=1 over T0..T32; oTimeout=0.
- Poll success: iRS=0, iPoll=1; bus 0x80 for the first two reads, then 0x05 → three EN pulses; oDATA=0x05, oDone at T99, oTimeout=0.
- Poll timeout: POLL_MAX=4, bus stuck at 0x80 → exactly 4 EN pulses; oDone and oTimeout both 1 at T132; oDATA=0x80; next start clears oTimeout.
- Ignored/level start: iStart held high for 200 cycles, plus extra pulses during oBusy → exactly one transaction, one oDone assertion.
- Reset mid-read: assert iRST_N=0 at T8 (EN high) → LCD_EN, LCD_RW, oBusy go to 0 immediately with no clock; after release, a new start completes normally at T33.
- Parameter corner: CLK_Divide=1, RECOVER=1, single read → EN high for 1 cycle, oDone at T3, data captured correctly.

Source files
------------

// File: rtl/lcd_reader_if.sv
// Request/response bundle between the LCD init/command sequencer and lcd_reader.
// The sequencer drives the request side; the reader returns captured data and status.
interface lcd_reader_if;
  logic       iStart;
  logic       iRS;
  logic       iPoll;
  logic [7:0] oDATA;
  logic       oDone;
  logic       oTimeout;
  logic       oBusy;

  modport master (
    output iStart, iRS, iPoll,
    input  oDATA, oDone, oTimeout, oBusy
  );

  modport slave (
    input  iStart, iRS, iPoll,
    output oDATA, oDone, oTimeout, oBusy
  );
endinterface

// File: rtl/lcd_reader.sv
// HD44780 read-cycle engine: single read of data RAM/status, or busy-flag poll
// that repeats until BF clears or the retry limit is reached.
//
// state | meaning
// IDLE  | waiting for a start edge
// SETUP | RW/RS valid, one-cycle address setup before EN rises
// EN_HI | LCD_EN high, counting CLK_Divide; data captured on the last edge
// RECOV | LCD_EN low, counting RECOVER before completing or re-polling
module lcd_reader #(
  parameter int CLK_Divide = 16,
  parameter int RECOVER    = 16,
  parameter int POLL_MAX   = 255
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  lcd_reader_if.slave      bus,
  input  logic [7:0]       LCD_DATA,
  output logic             LCD_EN,
  output logic             LCD_RW,
  output logic             LCD_RS
);

  localparam int CNT_MAX = (CLK_Divide > RECOVER) ? CLK_Divide : RECOVER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_Divide - 1);
  localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVER - 1);
  localparam logic [7:0]       POLL_LAST = 8'(POLL_MAX);

  typedef enum logic [1:0] {IDLE, SETUP, EN_HI, RECOV} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       poll_cnt;
  logic             poll_q;
  logic             start_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             timeout_q;
  logic             busy_q;

  assign bus.oDATA    = data_q;
  assign bus.oDone    = done_q;
  assign bus.oTimeout = timeout_q;
  assign bus.oBusy    = busy_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      poll_cnt  <= '0;
      poll_q    <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_RS    <= 1'b0;
    end else begin
      start_q <= bus.iStart;
      case (state)
        IDLE: begin
          if (bus.iStart && !start_q) begin
            poll_q    <= bus.iPoll;
            LCD_RS    <= bus.iRS;
            LCD_RW    <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            poll_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          LCD_EN <= 1'b1;
          cnt    <= '0;
          state  <= EN_HI;
        end
        EN_HI: begin
          if (cnt == DIV_LAST) begin
            LCD_EN   <= 1'b0;
            data_q   <= LCD_DATA;
            poll_cnt <= poll_cnt + 8'd1;
            cnt      <= '0;
            state    <= RECOV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOV: begin
          if (cnt == REC_LAST) begin
            // data_q already holds this read's byte, so BF is data_q[7]
            if (!poll_q || !data_q[7] || poll_cnt == POLL_LAST) begin
              timeout_q <= poll_q && data_q[7];
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              LCD_RW    <= 1'b0;
              LCD_RS    <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= SETUP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
